// File: rtl/rnn_step_ctrl_if.sv
// Handshake and register-file bus between the RNN step sequencer and its environment.
// master drives requests and register-file data; slave is the sequencer.
interface rnn_step_ctrl_if #(
  parameter int unsigned IN_DIM  = 2,
  parameter int unsigned HID_DIM = 4,
  parameter int unsigned DATA_W  = 16
);
  localparam int unsigned MAX_DIM = (IN_DIM > HID_DIM) ? IN_DIM : HID_DIM;
  localparam int unsigned IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  logic              start;
  logic              clear_h;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  row_idx;
  logic [IDX_W-1:0]  col_idx;
  logic [DATA_W-1:0] x_data;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] u_data;
  logic [DATA_W-1:0] b_data;
  logic [IDX_W-1:0]  h_rd_idx;
  logic [DATA_W-1:0] h_rd_data;

  modport master (
    output start, clear_h, x_data, w_data, u_data, b_data, h_rd_idx,
    input  busy, done, row_idx, col_idx, h_rd_data
  );

  modport slave (
    input  start, clear_h, x_data, w_data, u_data, b_data, h_rd_idx,
    output busy, done, row_idx, col_idx, h_rd_data
  );
endinterface

// File: rtl/rnn_step_ctrl.sv
// Sequencer for one RNN time step: h_new[j] = act(b[j] + sum x[i]*W[i][j] + sum h[k]*U[k][j]).
// Optional ReLU activation enabled by defining RNN_RELU_EN; identity activation otherwise.
module rnn_step_ctrl #(
  parameter int unsigned IN_DIM  = 2,
  parameter int unsigned HID_DIM = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned FRAC    = 0
) (
  input logic             clk,
  input logic             rst_n,
  rnn_step_ctrl_if.slave  bus
);
  localparam int unsigned MAX_DIM = (IN_DIM > HID_DIM) ? IN_DIM : HID_DIM;
  localparam int unsigned IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int unsigned PROD_W  = 2 * DATA_W;

  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(IN_DIM - 1);
  localparam logic [IDX_W-1:0] LAST_HID = IDX_W'(HID_DIM - 1);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BIAS   = 3'd1;
  localparam logic [2:0] S_MAC_X  = 3'd2;
  localparam logic [2:0] S_MAC_H  = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]               state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [IDX_W-1:0]         row_q, row_d;
  logic [IDX_W-1:0]         col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] h_q  [HID_DIM];
  logic signed [DATA_W-1:0] h_d  [HID_DIM];
  logic signed [DATA_W-1:0] hn_q [HID_DIM];
  logic signed [DATA_W-1:0] hn_d [HID_DIM];

  logic signed [DATA_W-1:0] h_sel;
  logic signed [PROD_W-1:0] prod_x;
  logic signed [PROD_W-1:0] prod_h;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  sat_acc;
  logic signed [DATA_W-1:0] sat_val;
  logic signed [DATA_W-1:0] act_val;
  logic [DATA_W-1:0]        h_rd;

  // Datapath: MAC products, old-h operand select, rescale, saturate, activate
  always_comb begin
    h_sel = '0;
    for (int k = 0; k < HID_DIM; k++) begin
      if (row_q == IDX_W'(k)) h_sel = h_q[k];
    end
    prod_x  = $signed(bus.x_data) * $signed(bus.w_data);
    prod_h  = h_sel * $signed(bus.u_data);
    shifted = acc_q >>> FRAC;
    if (shifted > SAT_HI)      sat_acc = SAT_HI;
    else if (shifted < SAT_LO) sat_acc = SAT_LO;
    else                       sat_acc = shifted;
    sat_val = DATA_W'(sat_acc);
`ifdef RNN_RELU_EN
    if (sat_val[DATA_W-1]) act_val = '0;
    else                   act_val = sat_val;
`else
    act_val = sat_val;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    h_d     = h_q;
    hn_d    = hn_q;
    case (state_q)
      S_IDLE: begin
        row_d = '0;
        col_d = '0;
        if (bus.clear_h) begin
          for (int k = 0; k < HID_DIM; k++) h_d[k] = '0;
        end
        if (bus.start) begin
          state_d = S_BIAS;
          busy_d  = 1'b1;
        end
      end
      S_BIAS: begin
        acc_d   = ACC_W'($signed(bus.b_data));
        row_d   = '0;
        state_d = S_MAC_X;
      end
      S_MAC_X: begin
        acc_d = acc_q + ACC_W'(prod_x);
        if (row_q == LAST_IN) begin
          row_d   = '0;
          state_d = S_MAC_H;
        end else begin
          row_d = row_q + IDX_W'(1);
        end
      end
      S_MAC_H: begin
        acc_d = acc_q + ACC_W'(prod_h);
        if (row_q == LAST_HID) begin
          row_d   = '0;
          state_d = S_WB;
        end else begin
          row_d = row_q + IDX_W'(1);
        end
      end
      S_WB: begin
        for (int k = 0; k < HID_DIM; k++) begin
          if (col_q == IDX_W'(k)) hn_d[k] = act_val;
        end
        if (col_q == LAST_HID) begin
          state_d = S_COMMIT;
        end else begin
          col_d   = col_q + IDX_W'(1);
          state_d = S_BIAS;
        end
      end
      S_COMMIT: begin
        h_d     = hn_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      for (int k = 0; k < HID_DIM; k++) begin
        h_q[k]  <= '0;
        hn_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      h_q     <= h_d;
      hn_q    <= hn_d;
    end
  end

  // Readback always sees the committed vector only
  always_comb begin
    h_rd = '0;
    for (int k = 0; k < HID_DIM; k++) begin
      if (bus.h_rd_idx == IDX_W'(k)) h_rd = h_q[k];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.row_idx   = row_q;
  assign bus.col_idx   = col_q;
  assign bus.h_rd_data = h_rd;
endmodule

// File: tb/tb_rnn_step_ctrl.sv
// Directed self-checking bench for rnn_step_ctrl; expectations follow RNN_RELU_EN when defined.
module tb_rnn_step_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  logic signed [15:0] x_mem [4];
  logic signed [15:0] b_mem [4];
  logic signed [15:0] w_mem [4][4];
  logic signed [15:0] u_mem [4][4];

  rnn_step_ctrl_if #(.IN_DIM(2), .HID_DIM(4), .DATA_W(16)) bus ();

  rnn_step_ctrl #(
    .IN_DIM(2), .HID_DIM(4), .DATA_W(16), .ACC_W(40), .FRAC(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.x_data = x_mem[bus.row_idx];
  assign bus.w_data = w_mem[bus.row_idx][bus.col_idx];
  assign bus.u_data = u_mem[bus.row_idx][bus.col_idx];
  assign bus.b_data = b_mem[bus.col_idx];

  task automatic load_step1();
    x_mem = '{16'sd2, -16'sd3, 16'sd0, 16'sd0};
    b_mem = '{-16'sd2, -16'sd2, -16'sd1, -16'sd1};
    w_mem = '{'{16'sd2, -16'sd10, -16'sd10, 16'sd3},
              '{16'sd6, 16'sd9, 16'sd12, 16'sd1},
              '{16'sd0, 16'sd0, 16'sd0, 16'sd0},
              '{16'sd0, 16'sd0, 16'sd0, 16'sd0}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) u_mem[r][c] = '0;
  endtask

  // Runs one step and returns observations; callers do the comparisons
  task automatic run_step(input logic clr, input logic pulse_busy,
                          output int lat, output int ndone, output logic busy0,
                          output logic [15:0] h0_pre, output logic [15:0] h0_post);
    bus.h_rd_idx = '0;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.clear_h = clr;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.clear_h = 1'b0;
    busy0   = bus.busy;
    lat     = -1;
    ndone   = 0;
    h0_pre  = 'x;
    h0_post = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (c == 32) h0_pre  = bus.h_rd_data;
      if (c == 33) h0_post = bus.h_rd_data;
      if (pulse_busy) begin
        bus.start   = (c == 5) || (c == 33);
        bus.clear_h = (c == 5);
      end
    end
    bus.start   = 1'b0;
    bus.clear_h = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.row_idx !== 2'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", bus.row_idx); end
    n_cmp++; if (bus.col_idx !== 2'd0) begin n_fail++; $display("FAIL reset_col: got %0d expected 0", bus.col_idx); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== 16'd0) begin
        n_fail++; $display("FAIL reset_h[%0d]: got %0d expected 0", k, $signed(bus.h_rd_data));
      end
    end
  endtask

  task automatic test_step1();
    int lat, nd; logic b0; logic [15:0] pre, post;
    logic signed [15:0] e [4];
`ifdef RNN_RELU_EN
    e = '{16'sd0, 16'sd0, 16'sd0, 16'sd2};
`else
    e = '{-16'sd16, -16'sd49, -16'sd57, 16'sd2};
`endif
    load_step1();
    run_step(1'b0, 1'b0, lat, nd, b0, pre, post);
    n_cmp++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL step1_busy: got %b expected 1", b0); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL step1_latency: got %0d expected 33", lat); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL step1_done_count: got %0d expected 1", nd); end
    n_cmp++; if (pre !== 16'd0) begin n_fail++; $display("FAIL step1_h0_before_commit: got %0d expected 0", $signed(pre)); end
    n_cmp++; if (post !== e[0]) begin n_fail++; $display("FAIL step1_h0_after_commit: got %0d expected %0d", $signed(post), e[0]); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== e[k]) begin
        n_fail++; $display("FAIL step1_h[%0d]: got %0d expected %0d", k, $signed(bus.h_rd_data), e[k]);
      end
    end
  endtask

  task automatic test_step2();
    int lat, nd; logic b0; logic [15:0] pre, post;
    logic signed [15:0] e [4];
    logic signed [15:0] old0;
`ifdef RNN_RELU_EN
    e = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    old0 = 16'sd0;
`else
    e = '{-16'sd185, -16'sd1126, -16'sd44, 16'sd1026};
    old0 = -16'sd16;
`endif
    u_mem = '{'{-16'sd2, -16'sd3, -16'sd5, -16'sd3},
              '{-16'sd1, 16'sd10, -16'sd2, -16'sd6},
              '{16'sd4, 16'sd11, 16'sd3, -16'sd12},
              '{-16'sd11, -16'sd4, 16'sd3, -16'sd1}};
    run_step(1'b0, 1'b0, lat, nd, b0, pre, post);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL step2_latency: got %0d expected 33", lat); end
    n_cmp++; if (pre !== old0) begin n_fail++; $display("FAIL step2_h0_before_commit: got %0d expected %0d", $signed(pre), old0); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== e[k]) begin
        n_fail++; $display("FAIL step2_h[%0d]: got %0d expected %0d", k, $signed(bus.h_rd_data), e[k]);
      end
    end
  endtask

  task automatic test_clear_start();
    int lat, nd; logic b0; logic [15:0] pre, post;
    logic signed [15:0] e [4];
`ifdef RNN_RELU_EN
    e = '{16'sd0, 16'sd0, 16'sd0, 16'sd2};
`else
    e = '{-16'sd16, -16'sd49, -16'sd57, 16'sd2};
`endif
    run_step(1'b1, 1'b0, lat, nd, b0, pre, post);
    n_cmp++; if (pre !== 16'd0) begin n_fail++; $display("FAIL clear_h0_cleared: got %0d expected 0", $signed(pre)); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL clear_done_count: got %0d expected 1", nd); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== e[k]) begin
        n_fail++; $display("FAIL clear_h[%0d]: got %0d expected %0d", k, $signed(bus.h_rd_data), e[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd; logic b0; logic [15:0] pre, post;
    logic signed [15:0] e [4];
`ifdef RNN_RELU_EN
    e = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
`else
    e = '{-16'sd185, -16'sd1126, -16'sd44, 16'sd1026};
`endif
    run_step(1'b0, 1'b1, lat, nd, b0, pre, post);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 33", lat); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", nd); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle_after: got %b expected 0", bus.busy); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== e[k]) begin
        n_fail++; $display("FAIL busy_start_h[%0d]: got %0d expected %0d", k, $signed(bus.h_rd_data), e[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat, nd; logic b0; logic [15:0] pre, post;
    x_mem = '{16'sd32767, 16'sd32767, 16'sd0, 16'sd0};
    b_mem = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        w_mem[r][c] = 16'sd32767;
        u_mem[r][c] = '0;
      end
    run_step(1'b1, 1'b0, lat, nd, b0, pre, post);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL sat_pos_latency: got %0d expected 33", lat); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== 16'sd32767) begin
        n_fail++; $display("FAIL sat_pos_h[%0d]: got %0d expected 32767", k, $signed(bus.h_rd_data));
      end
    end
  endtask

  task automatic test_reset_mid_step();
    int lat, nd; logic b0; logic [15:0] pre, post;
    logic signed [15:0] eneg;
    int ndone_idle;
`ifdef RNN_RELU_EN
    eneg = 16'sd0;
`else
    eneg = -16'sd32768;
`endif
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== 16'd0) begin
        n_fail++; $display("FAIL rstmid_h[%0d]: got %0d expected 0", k, $signed(bus.h_rd_data));
      end
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ndone_idle = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone_idle++;
    end
    n_cmp++; if (ndone_idle !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", ndone_idle); end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) w_mem[r][c] = -16'sd32767;
    run_step(1'b0, 1'b0, lat, nd, b0, pre, post);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL rstmid_restart_latency: got %0d expected 33", lat); end
    for (int k = 0; k < 4; k++) begin
      bus.h_rd_idx = 2'(k); #1;
      n_cmp++;
      if (bus.h_rd_data !== eneg) begin
        n_fail++; $display("FAIL sat_neg_h[%0d]: got %0d expected %0d", k, $signed(bus.h_rd_data), eneg);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.clear_h  = 1'b0;
    bus.h_rd_idx = '0;
    load_step1();
    test_reset();
    test_step1();
    test_step2();
    test_clear_start();
    test_back_to_back();
    test_saturation();
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
